alu_instr_sequencer: RTL and testbench

- Sequences one ALU-class instruction (opcode 1000_r_fff) around the 8-bit arithmetic/logic unit.
- Decodes the instruction and drives the 3-bit function code to the ALU. Holds the ALU enable for a parameterised relay-settle interval.
- Then latches the ALU result into destination register A or D and updates the Carry/Zero/Sign condition register.
- Sits directly downstream of the instruction register and directly upstream/downstream of the ALU.

---
 rtl/alu_instr_sequencer_if.sv | 37 +++
 rtl/alu_instr_sequencer.sv | 145 ++++++++++++++
 tb/tb_alu_instr_sequencer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_instr_sequencer_if.sv
// Bus between the ALU instruction sequencer and its neighbours:
// instruction register, ALU and the register/flag consumers.
interface alu_instr_sequencer_if;
  logic       start;
  logic [7:0] instr;
  logic [7:0] alu_result;
  logic       alu_carry;
  logic       alu_zero;
  logic [2:0] fctn_code;
  logic       alu_enable;
  logic       busy;
  logic       done;
  logic       illegal;
  logic [7:0] reg_a;
  logic [7:0] reg_d;
  logic       flag_carry;
  logic       flag_zero;
  logic       flag_sign;

  modport master (
    output start, instr,
    output alu_result, alu_carry, alu_zero,
    input  fctn_code, alu_enable,
    input  busy, done, illegal,
    input  reg_a, reg_d,
    input  flag_carry, flag_zero, flag_sign
  );

  modport slave (
    input  start, instr,
    input  alu_result, alu_carry, alu_zero,
    output fctn_code, alu_enable,
    output busy, done, illegal,
    output reg_a, reg_d,
    output flag_carry, flag_zero, flag_sign
  );
endinterface

// File: rtl/alu_instr_sequencer.sv
// Runs one ALU-class instruction: decode, hold the ALU enable
// while the relays settle, then latch result and C/Z/S flags.
module alu_instr_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 3
) (
  input logic                  clk,
  input logic                  rst_n,
  alu_instr_sequencer_if.slave io_bus
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("SETTLE_CYCLES must be in 1..15");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_SETTLE,
    S_LATCH,
    S_DONE
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_cnt;
  logic [2:0] r_fctn;
  logic       r_dest;
  logic       r_illegal;
  logic [7:0] r_a;
  logic [7:0] r_d;
  logic       r_c;
  logic       r_z;
  logic       r_s;

  logic       w_alu_op;
  logic       w_accept;
  logic       w_reject;
  logic       w_en;
  logic       w_busy;
  logic       w_done;
  logic [7:0] w_val;
  logic       w_c;
  logic       w_z;
  logic       w_s;

  assign w_alu_op = io_bus.instr[7:4] == 4'b1000;
  assign w_accept = (r_state == S_IDLE) && io_bus.start && w_alu_op;
  assign w_reject = (r_state == S_IDLE) && io_bus.start && !w_alu_op;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_en   = 1'b0;
    w_busy = 1'b1;
    w_done = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (w_accept) w_next = S_DECODE;
      end
      S_DECODE: w_next = S_SETTLE;
      S_SETTLE: begin
        w_en = 1'b1;
        if (r_cnt == 4'd0) w_next = S_LATCH;
      end
      S_LATCH: begin
        w_en   = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Logic ops clear carry; CLR ignores the ALU bus entirely.
  always_comb begin
    w_val = io_bus.alu_result;
    w_z   = io_bus.alu_zero;
    w_s   = io_bus.alu_result[7];
    w_c   = 1'b0;
    unique case (r_fctn)
      3'b000, 3'b001, 3'b110: w_c = io_bus.alu_carry;
      3'b111: begin
        w_val = 8'h00;
        w_z   = 1'b1;
        w_s   = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt     <= 4'd0;
      r_fctn    <= 3'b000;
      r_dest    <= 1'b0;
      r_illegal <= 1'b0;
      r_a       <= 8'h00;
      r_d       <= 8'h00;
      r_c       <= 1'b0;
      r_z       <= 1'b0;
      r_s       <= 1'b0;
    end else begin
      r_illegal <= w_reject;
      if (w_accept) begin
        r_fctn <= io_bus.instr[2:0];
        r_dest <= io_bus.instr[3];
      end else if (r_state == S_DONE) begin
        r_fctn <= 3'b000;
      end
      if (r_state == S_DECODE)
        r_cnt <= CNT_LOAD;
      else if (r_state == S_SETTLE && r_cnt != 4'd0)
        r_cnt <= r_cnt - 4'd1;
      if (r_state == S_LATCH) begin
        if (r_dest) r_d <= w_val;
        else        r_a <= w_val;
        r_c <= w_c;
        r_z <= w_z;
        r_s <= w_s;
      end
    end
  end

  assign io_bus.fctn_code  = r_fctn;
  assign io_bus.alu_enable = w_en;
  assign io_bus.busy       = w_busy;
  assign io_bus.done       = w_done;
  assign io_bus.illegal    = r_illegal;
  assign io_bus.reg_a      = r_a;
  assign io_bus.reg_d      = r_d;
  assign io_bus.flag_carry = r_c;
  assign io_bus.flag_zero  = r_z;
  assign io_bus.flag_sign  = r_s;

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Bench for alu_instr_sequencer: timeline model of each accepted
// instruction, checked every cycle, plus literal expectations.
module tb_alu_instr_sequencer;
  localparam int S = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_instr_sequencer_if bus ();

  alu_instr_sequencer #(.SETTLE_CYCLES(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_bus(bus)
  );

  int errors = 0;
  int checks = 0;
  int n_done = 0;
  int n_en   = 0;

  // Model: edge index of acceptance, captured instr, architectural state.
  int         e_cnt = 0;
  int         m_n   = 0;
  bit         m_act = 1'b0;
  logic [7:0] m_ins = 8'h00;
  logic [7:0] m_a   = 8'h00;
  logic [7:0] m_d   = 8'h00;
  logic       m_c   = 1'b0;
  logic       m_z   = 1'b0;
  logic       m_s   = 1'b0;
  logic       m_ill = 1'b0;

  always @(posedge clk) begin : model
    int dp;
    logic [2:0] f;
    dp = e_cnt - 1 - m_n;
    f  = m_ins[2:0];
    if (!rst_n) begin
      m_act <= 1'b0;
      m_a   <= 8'h00;
      m_d   <= 8'h00;
      m_c   <= 1'b0;
      m_z   <= 1'b0;
      m_s   <= 1'b0;
      m_ill <= 1'b0;
    end else begin
      m_ill <= 1'b0;
      if (m_act && dp == S + 1) begin
        if (f == 3'd7) begin
          if (m_ins[3]) m_d <= 8'h00;
          else          m_a <= 8'h00;
          m_z <= 1'b1;
          m_s <= 1'b0;
          m_c <= 1'b0;
        end else begin
          if (m_ins[3]) m_d <= bus.alu_result;
          else          m_a <= bus.alu_result;
          m_z <= bus.alu_zero;
          m_s <= bus.alu_result[7];
          m_c <= (f == 3'd0 || f == 3'd1 || f == 3'd6) ? bus.alu_carry : 1'b0;
        end
      end
      if (!m_act || dp >= S + 3) begin
        if (bus.start && bus.instr[7:4] == 4'h8) begin
          m_act <= 1'b1;
          m_n   <= e_cnt;
          m_ins <= bus.instr;
        end else if (bus.start) begin
          m_ill <= 1'b1;
        end
      end
    end
    e_cnt <= e_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    int d;
    logic b;
    logic [25:0] act;
    logic [25:0] exp;
    @(negedge clk);
    d = e_cnt - 1 - m_n;
    b = m_act && d <= S + 2;
    exp = {b ? m_ins[2:0] : 3'b000,
           m_act && d >= 1 && d <= S + 1, b,
           m_act && d == S + 2, m_ill,
           m_a, m_d, m_c, m_z, m_s};
    act = {bus.fctn_code, bus.alu_enable, bus.busy, bus.done, bus.illegal,
           bus.reg_a, bus.reg_d,
           bus.flag_carry, bus.flag_zero, bus.flag_sign};
    chk("cycle", {6'd0, act}, {6'd0, exp});
    if (bus.done === 1'b1) n_done++;
    if (bus.alu_enable === 1'b1) n_en++;
  endtask

  // Returns in the DONE cycle (or after the bound expires).
  task automatic run_op(input logic [7:0] ins, input logic [7:0] res,
                        input logic c, input logic z, output int lat);
    bus.instr      = ins;
    bus.alu_result = res;
    bus.alu_carry  = c;
    bus.alu_zero   = z;
    bus.start      = 1'b1;
    n_en = 0;
    step();
    bus.start = 1'b0;
    bus.instr = ~ins;
    chk("fctn_decode", {29'd0, bus.fctn_code}, {29'd0, ins[2:0]});
    lat = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    chk("latency", lat, S + 2);
    chk("en_cycles", n_en, S + 1);
  endtask

  initial begin
    int lat;
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.instr      = 8'h00;
    bus.alu_result = 8'h00;
    bus.alu_carry  = 1'b0;
    bus.alu_zero   = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_regs", {16'd0, bus.reg_a, bus.reg_d}, 32'h0000);
    chk("rst_flags", {29'd0, bus.flag_carry, bus.flag_zero, bus.flag_sign}, 32'd0);
    chk("rst_fctn", {29'd0, bus.fctn_code}, 32'd0);
    repeat (10) step();

    run_op(8'h80, 8'hF0, 1'b1, 1'b0, lat);
    chk("add_a", {24'd0, bus.reg_a}, 32'hF0);
    chk("add_d", {24'd0, bus.reg_d}, 32'h00);
    chk("add_czs", {29'd0, bus.flag_carry, bus.flag_zero, bus.flag_sign}, 32'b101);
    step();
    chk("add_idle", {31'd0, bus.busy}, 32'd0);

    run_op(8'h8A, 8'h00, 1'b1, 1'b1, lat);
    chk("and_d", {24'd0, bus.reg_d}, 32'h00);
    chk("and_czs", {29'd0, bus.flag_carry, bus.flag_zero, bus.flag_sign}, 32'b010);
    step();

    run_op(8'h89, 8'h81, 1'b0, 1'b0, lat);
    chk("inc_d", {24'd0, bus.reg_d}, 32'h81);
    chk("inc_a", {24'd0, bus.reg_a}, 32'hF0);
    step();

    run_op(8'h86, 8'hE0, 1'b1, 1'b0, lat);
    chk("shl_a", {24'd0, bus.reg_a}, 32'hE0);
    chk("shl_czs", {29'd0, bus.flag_carry, bus.flag_zero, bus.flag_sign}, 32'b101);
    step();

    run_op(8'h8C, 8'h3C, 1'b1, 1'b0, lat);
    chk("xor_d", {24'd0, bus.reg_d}, 32'h3C);
    chk("xor_czs", {29'd0, bus.flag_carry, bus.flag_zero, bus.flag_sign}, 32'b000);
    step();

    run_op(8'h8F, 8'hFF, 1'b1, 1'b0, lat);
    chk("clr_d", {24'd0, bus.reg_d}, 32'h00);
    chk("clr_czs", {29'd0, bus.flag_carry, bus.flag_zero, bus.flag_sign}, 32'b010);
    chk("clr_done", {31'd0, bus.done}, 32'd1);
    step();

    bus.instr = 8'h40;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("ill_pulse", {31'd0, bus.illegal}, 32'd1);
    chk("ill_busy", {31'd0, bus.busy}, 32'd0);
    step();
    chk("ill_clear", {31'd0, bus.illegal}, 32'd0);
    chk("ill_regs", {16'd0, bus.reg_a, bus.reg_d}, 32'hE000);

    n_done = 0;
    bus.instr      = 8'h80;
    bus.alu_result = 8'h12;
    bus.alu_carry  = 1'b0;
    bus.alu_zero   = 1'b0;
    bus.start      = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    bus.instr = 8'h88;
    bus.start = 1'b1;
    step();
    step();
    bus.start = 1'b0;
    repeat (8) step();
    chk("busy_dones", n_done, 1);
    chk("busy_a", {24'd0, bus.reg_a}, 32'h12);
    chk("busy_d", {24'd0, bus.reg_d}, 32'h00);

    bus.instr      = 8'h81;
    bus.alu_result = 8'h77;
    bus.start      = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (4) step();
    chk("latch_en", {31'd0, bus.alu_enable}, 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_en", {31'd0, bus.alu_enable}, 32'd0);
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_regs", {16'd0, bus.reg_a, bus.reg_d}, 32'h0000);
    n_done = 0;
    repeat (4) step();
    chk("mid_rst_nodone", n_done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
